// File: rtl/dm_cache_fsm_pkg.sv
// Shared types for the direct-mapped write-back data cache.
// Address split, line/tag entry formats and controller states.
package cache_definition;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int LINE_W = 128;

  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 14;
  localparam int IDX_MSB = 13;
  localparam int IDX_LSB = 4;
  localparam int WRD_MSB = 3;
  localparam int WRD_LSB = 2;

  localparam int TAG_W = TAG_MSB - TAG_LSB + 1;
  localparam int IDX_W = IDX_MSB - IDX_LSB + 1;
  localparam int OFF_W = IDX_LSB;

  typedef logic [LINE_W-1:0] cache_data_type;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             valid;
    logic             dirty;
  } cache_table_type;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             we;
  } cache_index_type;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE,
    REREAD
  } cache_state_type;

  function automatic logic [WORD_W-1:0] get_word(
    input cache_data_type line,
    input logic [1:0]     sel
  );
    return line[{sel, 5'b00000} +: WORD_W];
  endfunction

  function automatic cache_data_type merge_word(
    input cache_data_type    line,
    input logic [1:0]        sel,
    input logic [WORD_W-1:0] word
  );
    cache_data_type res;
    res = line;
    res[{sel, 5'b00000} +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/dm_cache_data.sv
// Line-data array: one synchronous port, read data updates only
// on cycles without a write, matching the tag table.
module dm_cache_data
  import cache_definition::*;
#(
  parameter int NUM_LINES = 1024
) (
  input  logic            clk,
  input  cache_index_type data_req,
  input  cache_data_type  data_write,
  output cache_data_type  data_read
);

  cache_data_type mem [NUM_LINES];

  always_ff @(posedge clk) begin
    if (data_req.we) begin
      mem[data_req.index] <= data_write;
    end else begin
      data_read <= mem[data_req.index];
    end
  end

endmodule

// File: rtl/dm_cache_fsm.sv
// Direct-mapped write-back, write-allocate cache controller.
// Drives tag table and data array; handles refill and victim write-back.
module dm_cache_fsm
  import cache_definition::*;
#(
  parameter int NUM_LINES = 1024,
  parameter bit INIT_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  input  logic                  cpu_rw,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [WORD_W-1:0]     cpu_wdata,
  output logic [WORD_W-1:0]     cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_valid,
  output logic                  mem_rw,
  output logic [ADDR_W-1:0]     mem_addr,
  output cache_data_type        mem_wdata,
  input  cache_data_type        mem_rdata,
  input  logic                  mem_ready,
  output cache_index_type       table_index,
  output cache_table_type       table_write,
  input  cache_table_type       table_read,
  output cache_index_type       data_index,
  output cache_data_type        data_write,
  input  cache_data_type        data_read
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LINES - 1);

  cache_state_type state;
  cache_state_type state_nx;

  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  cnt_nx;

  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              req_rw;

  cache_data_type    vic_line;
  logic [TAG_W-1:0]  vic_tag;

  logic              accept;
  logic              vic_load;
  logic              hit;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        req_word;
  logic [IDX_W-1:0]  cpu_idx;

  assign req_tag  = req_addr[TAG_MSB:TAG_LSB];
  assign req_idx  = req_addr[IDX_MSB:IDX_LSB];
  assign req_word = req_addr[WRD_MSB:WRD_LSB];
  assign cpu_idx  = cpu_addr[IDX_MSB:IDX_LSB];

  assign hit = table_read.valid
            && (table_read.tag == req_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (INIT_EN) begin
        state <= INIT;
      end else begin
        state <= IDLE;
      end
      cnt       <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_rw    <= 1'b0;
      vic_line  <= '0;
      vic_tag   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
        req_rw    <= cpu_rw;
      end
      if (vic_load) begin
        vic_line <= data_read;
        vic_tag  <= table_read.tag;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    accept      = 1'b0;
    vic_load    = 1'b0;
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    mem_valid   = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    table_index = '{index: req_idx, we: 1'b0};
    table_write = '0;
    data_index  = '{index: req_idx, we: 1'b0};
    data_write  = '0;

    unique case (state)
      INIT: begin
        // Write strobe held off while reset is asserted
        table_index = '{index: cnt, we: !rst};
        cnt_nx      = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nx = IDLE;
        end
      end

      IDLE: begin
        table_index.index = cpu_idx;
        data_index.index  = cpu_idx;
        if (cpu_valid) begin
          accept   = 1'b1;
          state_nx = COMPARE;
        end
      end

      COMPARE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          state_nx  = IDLE;
          if (req_rw) begin
            table_index.we = 1'b1;
            data_index.we  = 1'b1;
            table_write    = '{tag: req_tag,
                               valid: 1'b1,
                               dirty: 1'b1};
            data_write     = merge_word(data_read,
                                        req_word,
                                        req_wdata);
          end else begin
            cpu_rdata = get_word(data_read, req_word);
          end
        end else if (table_read.valid && table_read.dirty) begin
          vic_load = 1'b1;
          state_nx = WRITE_BACK;
        end else begin
          state_nx = ALLOCATE;
        end
      end

      WRITE_BACK: begin
        mem_valid = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = {vic_tag, req_idx, {OFF_W{1'b0}}};
        mem_wdata = vic_line;
        if (mem_ready) begin
          state_nx = ALLOCATE;
        end
      end

      ALLOCATE: begin
        mem_valid = 1'b1;
        mem_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_ready) begin
          table_index.we = 1'b1;
          data_index.we  = 1'b1;
          table_write    = '{tag: req_tag,
                             valid: 1'b1,
                             dirty: 1'b0};
          data_write     = mem_rdata;
          state_nx       = REREAD;
        end
      end

      // Tables hold their outputs on write cycles; fetch the new line
      REREAD: begin
        state_nx = COMPARE;
      end

      default: begin
        state_nx = INIT;
      end
    endcase
  end

endmodule
